me_frame_scheduler: RTL and testbench

//  Sequences the motion estimator across one frame: walks the 16x16 macroblock grid in raster order,

---
 rtl/mpeg2_pkg.sv | 21 ++
 rtl/mb_grid_counter.sv | 39 +++
 rtl/me_frame_scheduler.sv | 119 +++++++++++
 tb/tb_me_frame_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpeg2_pkg.sv
// rtl/mpeg2_pkg.sv - shared grid constants and scheduler FSM encoding for the motion-estimation path
package mpeg2_pkg;

    localparam int MB_SIZE     = 16;
    localparam int DEF_MB_COLS = 40;
    localparam int DEF_MB_ROWS = 30;
    localparam int DEF_GOP_LEN = 12;

    // Wide enough for 64 macroblock columns/rows; ix/iy are {count,4'b0} in 10 bits.
    localparam int GRID_W = 6;

    typedef logic [2:0] sched_state_t;

    localparam sched_state_t ST_IDLE  = 3'd0;
    localparam sched_state_t ST_ISSUE = 3'd1;
    localparam sched_state_t ST_ACK   = 3'd2;
    localparam sched_state_t ST_RUN   = 3'd3;
    localparam sched_state_t ST_NEXT  = 3'd4;
    localparam sched_state_t ST_DONE  = 3'd5;

endpackage

// File: rtl/mb_grid_counter.sv
// rtl/mb_grid_counter.sv - raster-order macroblock column/row counter with last-macroblock flag
module mb_grid_counter
    import mpeg2_pkg::*;
#(
    parameter int MB_COLS = DEF_MB_COLS,
    parameter int MB_ROWS = DEF_MB_ROWS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              adv,
    output logic [GRID_W-1:0] col,
    output logic [GRID_W-1:0] row,
    output logic              last_mb
);

    logic last_col;

    assign last_col = (col == GRID_W'(MB_COLS - 1));
    assign last_mb  = last_col && (row == GRID_W'(MB_ROWS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (adv) begin
            if (last_col) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/me_frame_scheduler.sv
// rtl/me_frame_scheduler.sv - per-frame macroblock sequencer for the motion estimator; SCHED_PERF_EN adds perf_cycles
module me_frame_scheduler
    import mpeg2_pkg::*;
#(
    parameter int          MB_COLS   = DEF_MB_COLS,
    parameter int          MB_ROWS   = DEF_MB_ROWS,
    parameter int          GOP_LEN   = DEF_GOP_LEN,
    parameter logic [31:0] REF_BASE0 = 32'h0000_0000,
    parameter logic [31:0] REF_BASE1 = 32'h0004_B000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        out_ready,
    output logic        busy,
    output logic        frame_done,
    output logic        me_en,
    input  logic        me_rdy,
    output logic [9:0]  me_ix,
    output logic [9:0]  me_iy,
    output logic        me_intra,
    output logic        me_writeback,
`ifdef SCHED_PERF_EN
    output logic [31:0] perf_cycles,
`endif
    output logic [31:0] me_base
);

    localparam int GOP_W = (GOP_LEN > 1) ? $clog2(GOP_LEN) : 1;

    sched_state_t      state;
    logic [GOP_W-1:0]  gop_idx;
    logic              ref_sel;
    logic [GRID_W-1:0] col;
    logic [GRID_W-1:0] row;
    logic              last_mb;
    logic              grid_clr;
    logic              grid_adv;

    assign grid_clr = (state == ST_IDLE) && start;
    assign grid_adv = (state == ST_NEXT) && !abort && !last_mb;

    mb_grid_counter #(
        .MB_COLS (MB_COLS),
        .MB_ROWS (MB_ROWS)
    ) u_grid (
        .clk     (clk),
        .rst     (rst),
        .clr     (grid_clr),
        .adv     (grid_adv),
        .col     (col),
        .row     (row),
        .last_mb (last_mb)
    );

    // The counter only moves in NEXT, so ix/iy hold from ISSUE through RUN.
    assign me_ix      = {col, 4'b0000};
    assign me_iy      = {row, 4'b0000};
    assign me_en      = (state == ST_ISSUE) && me_rdy && out_ready;
    assign frame_done = (state == ST_DONE);
    assign me_base    = ref_sel ? REF_BASE1 : REF_BASE0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            me_intra     <= 1'b0;
            me_writeback <= 1'b0;
            gop_idx      <= '0;
            ref_sel      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state        <= ST_ISSUE;
                        busy         <= 1'b1;
                        me_intra     <= (gop_idx == '0);
                        me_writeback <= (gop_idx != GOP_W'(GOP_LEN - 1));
                    end
                end
                ST_ISSUE: if (me_rdy && out_ready) state <= ST_ACK;
                ST_ACK:   if (!me_rdy) state <= ST_RUN;
                ST_RUN:   if (me_rdy) state <= ST_NEXT;
                ST_NEXT: begin
                    // An aborted frame leaves GOP position and reference select untouched.
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (last_mb) begin
                        state <= ST_DONE;
                    end else begin
                        state <= ST_ISSUE;
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    gop_idx <= (gop_idx == GOP_W'(GOP_LEN - 1)) ? '0 : gop_idx + 1'b1;
                    if (me_writeback) ref_sel <= ~ref_sel;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SCHED_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles <= '0;
        end else if (grid_clr) begin
            perf_cycles <= '0;
        end else if (busy) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_me_frame_scheduler.sv
// tb/tb_me_frame_scheduler.sv - frame-level model and directed checks for me_frame_scheduler
module tb_me_frame_scheduler;

    localparam int          COLS = 2;
    localparam int          ROWS = 2;
    localparam int          GOP  = 3;
    localparam logic [31:0] B0   = 32'h0000_0000;
    localparam logic [31:0] B1   = 32'h0004_B000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        out_ready;
    logic        busy;
    logic        frame_done;
    logic        me_en;
    logic        me_rdy;
    logic [9:0]  me_ix;
    logic [9:0]  me_iy;
    logic        me_intra;
    logic        me_writeback;
    logic [31:0] me_base;
`ifdef SCHED_PERF_EN
    logic [31:0] perf_cycles;
`endif

    me_frame_scheduler #(
        .MB_COLS   (COLS),
        .MB_ROWS   (ROWS),
        .GOP_LEN   (GOP),
        .REF_BASE0 (B0),
        .REF_BASE1 (B1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .out_ready    (out_ready),
        .busy         (busy),
        .frame_done   (frame_done),
        .me_en        (me_en),
        .me_rdy       (me_rdy),
        .me_ix        (me_ix),
        .me_iy        (me_iy),
        .me_intra     (me_intra),
        .me_writeback (me_writeback),
`ifdef SCHED_PERF_EN
        .perf_cycles  (perf_cycles),
`endif
        .me_base      (me_base)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int en_count = 0;
    int done_count = 0;
    int busy_cyc = 0;

    // Frame-level model: GOP position, reference select, and the macroblocks still owed.
    int          m_gop = 0;
    bit          m_ref = 1'b0;
    bit          model_busy = 1'b0;
    bit          cur_intra = 1'b0;
    bit          cur_wb = 1'b0;
    logic [31:0] cur_base = B0;
    int          qx[$];
    int          qy[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_start();
        if (model_busy) return;
        model_busy = 1'b1;
        cur_intra  = (m_gop == 0);
        cur_wb     = (m_gop != GOP - 1);
        cur_base   = m_ref ? B1 : B0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                qx.push_back(c * 16);
                qy.push_back(r * 16);
            end
    endtask

    task automatic model_abort();
        qx.delete();
        qy.delete();
        model_busy = 1'b0;
    endtask

    task automatic model_reset();
        model_abort();
        m_gop = 0;
        m_ref = 1'b0;
    endtask

    // Behavioural estimator: accepts en, goes not-ready for 5 cycles, then ready again.
    initial begin
        me_rdy = 1'b1;
        forever begin
            @(negedge clk);
            if (me_en) begin
                @(posedge clk);
                #1 me_rdy = 1'b0;
                repeat (5) @(posedge clk);
                #1 me_rdy = 1'b1;
            end
        end
    end

    // Compare process: every en against the next owed macroblock, frame attributes while busy.
    initial begin
        forever begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (me_en) begin
                en_count++;
                check("en_expected", 32'(qx.size() != 0), 32'd1);
                if (qx.size() != 0) begin
                    check("me_ix", 32'(me_ix), 32'(qx.pop_front()));
                    check("me_iy", 32'(me_iy), 32'(qy.pop_front()));
                end
            end
            if (frame_done) begin
                done_count++;
                check("frame_done_expected", 32'(model_busy && qx.size() == 0), 32'd1);
                if (model_busy) begin
                    model_busy = 1'b0;
                    if (cur_wb) m_ref = ~m_ref;
                    m_gop = (m_gop + 1) % GOP;
                end
            end
            if (busy) begin
                check("me_intra", 32'(me_intra), 32'(cur_intra));
                check("me_writeback", 32'(me_writeback), 32'(cur_wb));
                check("me_base", me_base, cur_base);
            end
        end
    end

    task automatic start_frame();
        @(negedge clk);
        start = 1'b1;
        model_start();
        busy_cyc = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_idle: busy still %0d after %0d cycles, required 0", busy, limit);
        end
    endtask

    task automatic wait_en(input int target, input int limit);
        int n = 0;
        while (en_count < target && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("wait_en_reached", 32'(en_count >= target), 32'd1);
    endtask

    task automatic run_frame(input bit li, input bit lw, input logic [31:0] lb, input bit restart_mid);
        int e0 = en_count;
        int d0 = done_count;
        start_frame();
        check("busy_after_start", 32'(busy), 32'd1);
        check("intra_literal", 32'(me_intra), 32'(li));
        check("writeback_literal", 32'(me_writeback), 32'(lw));
        check("base_literal", me_base, lb);
        if (restart_mid) begin
            repeat (10) @(negedge clk);
            start = 1'b1;
            model_start();
            @(negedge clk);
            start = 1'b0;
        end
        wait_idle(400);
        check("en_per_frame", 32'(en_count - e0), 32'd4);
        check("done_per_frame", 32'(done_count - d0), 32'd1);
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e0;
        int d0;
        int n;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_me_en", 32'(me_en), 32'd0);
        check("rst_intra", 32'(me_intra), 32'd0);
        check("rst_writeback", 32'(me_writeback), 32'd0);
        check("rst_ix", 32'(me_ix), 32'd0);
        check("rst_iy", 32'(me_iy), 32'd0);
        check("rst_base", me_base, B0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Frames 0..2 of a GOP, then GOP wraps.
        run_frame(1'b1, 1'b1, B0, 1'b0);
        run_frame(1'b0, 1'b1, B1, 1'b0);
        run_frame(1'b0, 1'b0, B0, 1'b0);

        // Back-end stall before the second macroblock.
        e0 = en_count;
        d0 = done_count;
        start_frame();
        check("f3_intra_literal", 32'(me_intra), 32'd1);
        check("f3_base_literal", me_base, B0);
        wait_en(e0 + 1, 50);
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (20) @(negedge clk);
        check("stall_no_en", 32'(en_count - e0), 32'd1);
        check("stall_rdy_high", 32'(me_rdy), 32'd1);
        check("stall_me_en_low", 32'(me_en), 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        #1 check("en_same_cycle", 32'(me_en), 32'd1);
        wait_idle(400);
        check("stall_en_total", 32'(en_count - e0), 32'd4);
        check("stall_done_total", 32'(done_count - d0), 32'd1);

        // Abort during RUN of macroblock 1.
        e0 = en_count;
        d0 = done_count;
        start_frame();
        check("f4_intra_literal", 32'(me_intra), 32'd0);
        check("f4_base_literal", me_base, B1);
        wait_en(e0 + 2, 50);
        repeat (2) @(posedge clk);
        #1 abort = 1'b1;
        model_abort();
        wait_idle(100);
        abort = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_en_total", 32'(en_count - e0), 32'd2);
        check("abort_no_done", 32'(done_count - d0), 32'd0);
        run_frame(1'b0, 1'b1, B1, 1'b0);

        // Asynchronous reset mid-RUN of macroblock 1.
        e0 = en_count;
        start_frame();
        check("f6_intra_literal", 32'(me_intra), 32'd0);
        check("f6_writeback_literal", 32'(me_writeback), 32'd0);
        wait_en(e0 + 2, 50);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ix", 32'(me_ix), 32'd0);
        check("arst_iy", 32'(me_iy), 32'd0);
        check("arst_intra", 32'(me_intra), 32'd0);
        check("arst_writeback", 32'(me_writeback), 32'd0);
        check("arst_base", me_base, B0);
        check("arst_me_en", 32'(me_en), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (!me_rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rdy_back_after_reset", 32'(me_rdy), 32'd1);

        // Fresh frame after reset, with a start pulse that must be ignored mid-frame.
        run_frame(1'b1, 1'b1, B0, 1'b1);
`ifdef SCHED_PERF_EN
        check("perf_cycles_literal", perf_cycles, 32'd33);
        check("perf_vs_busy", perf_cycles, 32'(busy_cyc));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
